// File: rtl/cache_types.sv
// cache_types: types and helpers shared by the cache replacement logic.
//   plru_t     - 3-bit tree-PLRU word: [0] root, [1] A/B leaf, [2] C/D leaf
//   way_idx_t  - 2-bit way index (0=A, 1=B, 2=C, 3=D)
//   plru_victim() - way a given PLRU word points at for eviction
package cache_types;

    typedef logic [2:0] plru_t;
    typedef logic [1:0] way_idx_t;

    localparam way_idx_t WAY_A = 2'd0;
    localparam way_idx_t WAY_B = 2'd1;
    localparam way_idx_t WAY_C = 2'd2;
    localparam way_idx_t WAY_D = 2'd3;

    // Root picks the half, then that half's leaf picks the way.
    function automatic way_idx_t plru_victim(input plru_t p);
        if (!p[0]) begin
            return p[1] ? WAY_B : WAY_A;
        end
        return p[2] ? WAY_D : WAY_C;
    endfunction

endpackage

// File: rtl/plru_touch.sv
// plru_touch: combinational tree-PLRU update for one access.
//   cur - PLRU word before the access
//   way - way that was accessed
//   nxt - PLRU word pointing away from that way; the other leaf is kept
module plru_touch
    import cache_types::*;
(
    input  plru_t    cur,
    input  way_idx_t way,
    output plru_t    nxt
);

    always_comb begin
        // NOTE: default assignment first so every path drives nxt and no latch is inferred.
        nxt = cur;
        case (way)
            WAY_A: begin nxt[0] = 1'b1; nxt[1] = 1'b1; end
            WAY_B: begin nxt[0] = 1'b1; nxt[1] = 1'b0; end
            WAY_C: begin nxt[0] = 1'b0; nxt[2] = 1'b1; end
            default: begin nxt[0] = 1'b0; nxt[2] = 1'b0; end
        endcase
    end

endmodule

// File: rtl/plru_tracker.sv
// plru_tracker: per-set 4-way tree-PLRU state with victim lookup and flush.
//   clk, rst               - clock, asynchronous active-high reset
//   flush_req / busy       - start a sweep clearing every set / sweep running
//   rd_en, rd_set          - victim lookup request
//   rd_valid, lru_bits,
//   victim_way             - lookup result one cycle later (held otherwise)
//   touch_en, touch_set,
//   touch_way              - record an access (hit or fill)
module plru_tracker
    import cache_types::*;
#(
    parameter int NUM_SETS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_req,
    output logic                        busy,
    input  logic                        rd_en,
    input  logic [$clog2(NUM_SETS)-1:0] rd_set,
    output logic                        rd_valid,
    output logic [2:0]                  lru_bits,
    output logic [1:0]                  victim_way,
    input  logic                        touch_en,
    input  logic [$clog2(NUM_SETS)-1:0] touch_set,
    input  logic [1:0]                  touch_way
);

    localparam int SET_W = $clog2(NUM_SETS);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]       state;
    logic [SET_W-1:0] flush_cnt;
    plru_t            mem [NUM_SETS];

    plru_t touch_cur;
    plru_t touch_nxt;
    plru_t rd_data;
    logic  touch_fire;
    logic  rd_fire;

    assign busy       = (state == ST_FLUSH);
    assign touch_fire = touch_en & ~busy;
    assign rd_fire    = rd_en & ~busy;
    assign touch_cur  = mem[touch_set];

    // One update instance serves both the store and the same-set read bypass.
    plru_touch u_touch (
        .cur (touch_cur),
        .way (touch_way),
        .nxt (touch_nxt)
    );

    // Write-first: a read of the set being touched sees the updated word.
    always_comb begin
        rd_data = mem[rd_set];
        if (touch_fire && (touch_set == rd_set)) begin
            rd_data = touch_nxt;
        end
    end

    // NOTE: the PLRU array is reset explicitly; it is flop-based, and an
    // asynchronous clear must leave every set pointing at way A at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                mem[i] <= '0;
            end
        end else if (busy) begin
            mem[flush_cnt] <= '0;
        end else if (touch_fire) begin
            mem[touch_set] <= touch_nxt;
        end
    end

    // A touch in the same cycle as flush_req is stored above and wiped by the sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all sequential state so every
            // flop samples pre-edge values regardless of statement order.
            state     <= ST_IDLE;
            flush_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (flush_req) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= '0;
                    end
                end
                ST_FLUSH: begin
                    flush_cnt <= flush_cnt + 1'b1;
                    if (flush_cnt == SET_W'(NUM_SETS - 1)) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid   <= 1'b0;
            lru_bits   <= '0;
            victim_way <= '0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                lru_bits   <= rd_data;
                victim_way <= plru_victim(rd_data);
            end
        end
    end

endmodule

// File: tb/tb_plru_tracker.sv
// tb_plru_tracker: directed self-checking bench for plru_tracker.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_plru_tracker;

    localparam int NUM_SETS = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush_req;
    logic       busy;
    logic       rd_en;
    logic [3:0] rd_set;
    logic       rd_valid;
    logic [2:0] lru_bits;
    logic [1:0] victim_way;
    logic       touch_en;
    logic [3:0] touch_set;
    logic [1:0] touch_way;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    plru_tracker #(.NUM_SETS(NUM_SETS)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_req  (flush_req),
        .busy       (busy),
        .rd_en      (rd_en),
        .rd_set     (rd_set),
        .rd_valid   (rd_valid),
        .lru_bits   (lru_bits),
        .victim_way (victim_way),
        .touch_en   (touch_en),
        .touch_set  (touch_set),
        .touch_way  (touch_way)
    );

    // Stimulus helpers: entered at a falling edge, return at the next one.
    task automatic touch(input logic [3:0] s, input logic [1:0] w);
        touch_en  = 1'b1;
        touch_set = s;
        touch_way = w;
        @(negedge clk);
        touch_en  = 1'b0;
    endtask

    task automatic lookup(input logic [3:0] s);
        rd_en  = 1'b1;
        rd_set = s;
        @(negedge clk);
        rd_en  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush_req = 1'b0; rd_en = 1'b0; rd_set = '0;
        touch_en = 1'b0; touch_set = '0; touch_way = '0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, want 0", busy); end
        n_checks++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b, want 0", rd_valid); end
        n_checks++;
        if (lru_bits !== 3'b000) begin n_fail++; $display("FAIL reset_lru: got %b, want 000", lru_bits); end
        n_checks++;
        if (victim_way !== 2'd0) begin n_fail++; $display("FAIL reset_victim: got %0d, want 0", victim_way); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_after_reset;
        lookup(4'd5);
        n_checks++;
        if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL rd5_valid: got %b, want 1", rd_valid); end
        n_checks++;
        if (lru_bits !== 3'b000) begin n_fail++; $display("FAIL rd5_lru: got %b, want 000", lru_bits); end
        n_checks++;
        if (victim_way !== 2'd0) begin n_fail++; $display("FAIL rd5_victim: got %0d, want 0", victim_way); end
        @(negedge clk);
        n_checks++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd5_pulse: got %b, want 0", rd_valid); end
    endtask

    task automatic test_touch_single;
        // Touch A on a clear set: root -> C/D, A/B leaf -> B.
        touch(4'd3, 2'd0);
        lookup(4'd3);
        n_checks++;
        if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL t3a_valid: got %b, want 1", rd_valid); end
        n_checks++;
        if (lru_bits !== 3'b011) begin n_fail++; $display("FAIL t3a_lru: got %b, want 011", lru_bits); end
        n_checks++;
        if (victim_way !== 2'd2) begin n_fail++; $display("FAIL t3a_victim: got %0d, want 2", victim_way); end
        // Outputs hold while no lookup is issued.
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (lru_bits !== 3'b011 || victim_way !== 2'd2) begin
            n_fail++; $display("FAIL hold: got %b/%0d, want 011/2", lru_bits, victim_way);
        end
    endtask

    task automatic test_back_to_back;
        // A -> 011, B -> 001, C -> 100, D -> 000: every bit last written to 0.
        touch_en = 1'b1; touch_set = 4'd3;
        for (int w = 0; w < 4; w++) begin
            touch_way = 2'(w);
            @(negedge clk);
        end
        touch_en = 1'b0;
        lookup(4'd3);
        n_checks++;
        if (lru_bits !== 3'b000) begin n_fail++; $display("FAIL abcd_lru: got %b, want 000", lru_bits); end
        n_checks++;
        if (victim_way !== 2'd0) begin n_fail++; $display("FAIL abcd_victim: got %0d, want 0", victim_way); end
    endtask

    task automatic test_forwarding;
        // Same-set touch C and read: read sees 100 -> root 0, leaf 0 -> A.
        touch_en = 1'b1; touch_set = 4'd7; touch_way = 2'd2;
        rd_en = 1'b1; rd_set = 4'd7;
        @(negedge clk);
        touch_en = 1'b0; rd_en = 1'b0;
        n_checks++;
        if (lru_bits !== 3'b100) begin n_fail++; $display("FAIL fwd7_lru: got %b, want 100", lru_bits); end
        n_checks++;
        if (victim_way !== 2'd0) begin n_fail++; $display("FAIL fwd7_victim: got %0d, want 0", victim_way); end
        // Different sets in the same cycle: no bypass.
        touch_en = 1'b1; touch_set = 4'd1; touch_way = 2'd1;
        rd_en = 1'b1; rd_set = 4'd2;
        @(negedge clk);
        touch_en = 1'b0; rd_en = 1'b0;
        n_checks++;
        if (lru_bits !== 3'b000) begin n_fail++; $display("FAIL nofwd_lru: got %b, want 000", lru_bits); end
        lookup(4'd1);
        n_checks++;
        if (lru_bits !== 3'b001 || victim_way !== 2'd2) begin
            n_fail++; $display("FAIL t1b: got %b/%0d, want 001/2", lru_bits, victim_way);
        end
    endtask

    task automatic test_flush;
        int cycles;
        for (int i = 0; i < NUM_SETS; i++) begin
            touch(4'(i), 2'(i % 4));
        end
        lookup(4'd4);
        n_checks++;
        if (lru_bits !== 3'b011 || victim_way !== 2'd2) begin
            n_fail++; $display("FAIL pre4: got %b/%0d, want 011/2", lru_bits, victim_way);
        end
        lookup(4'd6);
        n_checks++;
        if (lru_bits !== 3'b100 || victim_way !== 2'd0) begin
            n_fail++; $display("FAIL pre6: got %b/%0d, want 100/0", lru_bits, victim_way);
        end
        // Flush request together with a touch that the sweep must wipe.
        flush_req = 1'b1; touch_en = 1'b1; touch_set = 4'd9; touch_way = 2'd1;
        @(negedge clk);
        // Everything driven while busy must be ignored; set 0 is already
        // swept by the time later touches to it arrive.
        touch_set = 4'd0; touch_way = 2'd0;
        rd_en = 1'b1; rd_set = 4'd0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            n_checks++;
            if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL busy_rd_valid: got %b, want 0 (cycle %0d)", rd_valid, cycles); end
            cycles++;
            @(negedge clk);
        end
        flush_req = 1'b0; touch_en = 1'b0; rd_en = 1'b0;
        n_checks++;
        if (cycles != NUM_SETS) begin n_fail++; $display("FAIL busy_len: got %0d, want %0d", cycles, NUM_SETS); end
        n_checks++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL post_rd_valid: got %b, want 0", rd_valid); end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL no_reflush: got %b, want 0", busy); end
        for (int i = 0; i < NUM_SETS; i++) begin
            lookup(4'(i));
            n_checks++;
            if (rd_valid !== 1'b1 || lru_bits !== 3'b000 || victim_way !== 2'd0) begin
                n_fail++;
                $display("FAIL flushed_set%0d: got v=%b %b/%0d, want v=1 000/0", i, rd_valid, lru_bits, victim_way);
            end
        end
    endtask

    task automatic test_reset_mid_flush;
        for (int i = 10; i < NUM_SETS; i++) begin
            touch(4'(i), 2'd0);
        end
        lookup(4'd15);
        n_checks++;
        if (lru_bits !== 3'b011) begin n_fail++; $display("FAIL pre15: got %b, want 011", lru_bits); end
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b, want 1", busy); end
        @(negedge clk);
        @(negedge clk);
        // Assert reset between clock edges.
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b, want 0", busy); end
        n_checks++;
        if (rd_valid !== 1'b0 || lru_bits !== 3'b000 || victim_way !== 2'd0) begin
            n_fail++; $display("FAIL mid_rst_out: got v=%b %b/%0d, want v=0 000/0", rd_valid, lru_bits, victim_way);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_idle: got %b, want 0", busy); end
        for (int i = 0; i < NUM_SETS; i++) begin
            lookup(4'(i));
            n_checks++;
            if (lru_bits !== 3'b000) begin n_fail++; $display("FAIL rst_set%0d: got %b, want 000", i, lru_bits); end
        end
    endtask

    initial begin
        test_reset();
        test_read_after_reset();
        test_touch_single();
        test_back_to_back();
        test_forwarding();
        test_flush();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
